rlc_encoder: RTL and testbench

- Upstream neighbour of `rlc_decoder`.
- Accepts a stream of 4-bit symbols and run-length encodes them into 6-bit tokens {value[3:0], run[1:0]}, where run = copies − 1 (1..4 copies).
- Packs tokens MSB-first into 16-bit words and writes them toward the SRAM with a valid/ready handshake.
- The decoder consumes the resulting packed SRAM image.

---
 rtl/rlc_pkg.sv | 44 ++++
 rtl/rlc_encoder_if.sv | 26 ++
 rtl/rlc_bit_packer.sv | 100 ++++++++++
 rtl/rlc_encoder.sv | 129 ++++++++++++
 tb/tb_rlc_encoder.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rlc_pkg.sv
// Shared definitions for the run-length encoder and its decoder neighbour.
// Contents: field widths, FSM state codes, the token payload struct and the
// token pack/unpack helpers.
package rlc_pkg;

    localparam int unsigned SYM_W  = 4;
    localparam int unsigned RUN_W  = 2;
    localparam int unsigned TOK_W  = SYM_W + RUN_W;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BUF_W  = 32;
    localparam int unsigned FILL_W = 6;

    // Largest run field value (copies - 1)
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'((1 << RUN_W) - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_RUN        = 3'd1;
    localparam logic [2:0] ST_FLUSH_TOK  = 3'd2;
    localparam logic [2:0] ST_FLUSH_WORD = 3'd3;
    localparam logic [2:0] ST_DONE       = 3'd4;

    typedef struct packed {
        logic [SYM_W-1:0] value;
        logic [RUN_W-1:0] run;
    } token_t;

    function automatic token_t tok_pack(input logic [SYM_W-1:0] value,
                                        input logic [RUN_W-1:0] run);
        token_t t;
        t.value = value;
        t.run   = run;
        return t;
    endfunction

    function automatic logic [SYM_W-1:0] tok_value(input token_t t);
        return t.value;
    endfunction

    function automatic logic [RUN_W-1:0] tok_run(input token_t t);
        return t.run;
    endfunction

endpackage

// File: rtl/rlc_encoder_if.sv
// Symbol-in / word-out bus of the run-length encoder.
// in_valid/in_data/in_last/in_ready : symbol stream into the encoder
// sram_dout/sram_valid/sram_ready   : packed words toward the SRAM
// Modport slave is the encoder's view; master is the environment's view.
interface rlc_encoder_if;
    import rlc_pkg::*;

    logic              in_valid;
    logic [SYM_W-1:0]  in_data;
    logic              in_last;
    logic              in_ready;
    logic [WORD_W-1:0] sram_dout;
    logic              sram_valid;
    logic              sram_ready;

    modport slave (
        input  in_valid, in_data, in_last, sram_ready,
        output in_ready, sram_dout, sram_valid
    );

    modport master (
        output in_valid, in_data, in_last, sram_ready,
        input  in_ready, sram_dout, sram_valid
    );

endinterface

// File: rtl/rlc_bit_packer.sv
// Packs 6-bit tokens MSB-first into a left-aligned 32-bit buffer and drains
// it as 16-bit words through a valid/ready output register.
// clk, rst_n     : clock, async active-low reset
// clear_i        : drop buffered bits (new frame)
// tok_valid_i/tok_i : token append request
// flush_i        : allow a final zero-padded partial word
// run_nxt_i      : encoder will be in RUN next cycle (qualifies in_ready_o)
// dout_ready_i   : downstream accepts dout_o
// dout_o/dout_valid_o : output word register
// fill_o         : number of valid bits in the buffer
// in_ready_o     : room for another token in RUN
module rlc_bit_packer
    import rlc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              tok_valid_i,
    input  token_t            tok_i,
    input  logic              flush_i,
    input  logic              run_nxt_i,
    input  logic              dout_ready_i,
    output logic [WORD_W-1:0] dout_o,
    output logic              dout_valid_o,
    output logic [FILL_W-1:0] fill_o,
    output logic              in_ready_o
);

    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WORD_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              in_ready_q, in_ready_d;

    logic              out_free;
    logic              take_full;
    logic              take_part;
    logic [FILL_W-1:0] tok_sh;
    logic [BUF_W-1:0]  merged;
    logic [FILL_W-1:0] fill_add;

    // Append, extract and output-register update
    always_comb begin
        out_free  = !valid_q || dout_ready_i;
        take_full = out_free && (fill_q >= FILL_W'(WORD_W));
        // Partial word only once no more tokens can arrive
        take_part = out_free && flush_i && !tok_valid_i &&
                    (fill_q != '0) && (fill_q < FILL_W'(WORD_W));
        tok_sh    = FILL_W'(BUF_W - TOK_W) - fill_q;

        merged   = buf_q;
        fill_add = fill_q;
        if (tok_valid_i) begin
            merged   = buf_q | (BUF_W'(tok_i) << tok_sh);
            fill_add = fill_q + FILL_W'(TOK_W);
        end

        buf_d   = merged;
        fill_d  = fill_add;
        dout_d  = dout_q;
        valid_d = valid_q && !dout_ready_i;

        // Bits below fill are always zero, so a partial word is already padded
        if (take_full || take_part) begin
            dout_d  = buf_q[BUF_W-1 -: WORD_W];
            buf_d   = merged << WORD_W;
            fill_d  = take_full ? (fill_add - FILL_W'(WORD_W)) : '0;
            valid_d = 1'b1;
        end

        if (clear_i) begin
            buf_d  = '0;
            fill_d = '0;
        end

        in_ready_d = run_nxt_i && (fill_d < FILL_W'(WORD_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            fill_q     <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign fill_o       = fill_q;
    assign in_ready_o   = in_ready_q;

endmodule

// File: rtl/rlc_encoder.sv
// Run-length encoder: 4-bit symbols -> {value, copies-1} tokens -> packed
// 16-bit words toward the SRAM.
// clk, reset_n : clock, async active-low reset
// start        : begin a new frame (honoured in IDLE or DONE)
// bus          : symbol stream in, packed words out (rlc_encoder_if.slave)
// word_count   : words accepted in the current frame
// done         : one-cycle pulse once the frame's last word is accepted
module rlc_encoder
    import rlc_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    rlc_encoder_if.slave     bus,
    output logic [CNT_W-1:0] word_count,
    output logic             done
);

    logic [2:0]        state_q, state_d;
    logic [SYM_W-1:0]  cur_val_q, cur_val_d;
    logic [RUN_W-1:0]  cur_cnt_q, cur_cnt_d;
    logic              has_run_q, has_run_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              done_q, done_d;

    logic              accept;
    logic              acc;
    logic              tok_valid;
    token_t            tok;
    logic              clear;
    logic              run_nxt;
    logic [FILL_W-1:0] pk_fill;

    assign accept = (state_q == ST_RUN) && bus.in_valid && bus.in_ready;
    assign acc    = bus.sram_valid && bus.sram_ready;

    // Run tracking and frame sequencing
    always_comb begin
        state_d   = state_q;
        cur_val_d = cur_val_q;
        cur_cnt_d = cur_cnt_q;
        has_run_d = has_run_q;
        wcnt_d    = wcnt_q + CNT_W'(acc);
        tok_valid = 1'b0;
        tok       = tok_pack(cur_val_q, cur_cnt_q);
        clear     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    clear     = 1'b1;
                    wcnt_d    = '0;
                    has_run_d = 1'b0;
                    cur_val_d = '0;
                    cur_cnt_d = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (has_run_q && (bus.in_data == cur_val_q) &&
                        (cur_cnt_q != RUN_MAX)) begin
                        cur_cnt_d = cur_cnt_q + RUN_W'(1);
                    end else begin
                        // Close the current run (if any) and start a new one
                        tok_valid = has_run_q;
                        cur_val_d = bus.in_data;
                        cur_cnt_d = '0;
                        has_run_d = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = ST_FLUSH_TOK;
                    end
                end
            end
            ST_FLUSH_TOK: begin
                tok_valid = 1'b1;
                has_run_d = 1'b0;
                state_d   = ST_FLUSH_WORD;
            end
            ST_FLUSH_WORD: begin
                if ((pk_fill == '0) && (!bus.sram_valid || acc)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        run_nxt = (state_d == ST_RUN);
        done_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_val_q <= '0;
            cur_cnt_q <= '0;
            has_run_q <= 1'b0;
            wcnt_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_val_q <= cur_val_d;
            cur_cnt_q <= cur_cnt_d;
            has_run_q <= has_run_d;
            wcnt_q    <= wcnt_d;
            done_q    <= done_d;
        end
    end

    rlc_bit_packer u_packer (
        .clk          (clk),
        .rst_n        (reset_n),
        .clear_i      (clear),
        .tok_valid_i  (tok_valid),
        .tok_i        (tok),
        .flush_i      (state_q == ST_FLUSH_WORD),
        .run_nxt_i    (run_nxt),
        .dout_ready_i (bus.sram_ready),
        .dout_o       (bus.sram_dout),
        .dout_valid_o (bus.sram_valid),
        .fill_o       (pk_fill),
        .in_ready_o   (bus.in_ready)
    );

    assign word_count = wcnt_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rlc_encoder.sv
// Directed bench for rlc_encoder: hand-computed word images, backpressure,
// mid-frame reset and a decode-back of a pseudo-random frame.
module tb_rlc_encoder;
    import rlc_pkg::*;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] word_count;
    logic             done;

    rlc_encoder_if bus ();

    rlc_encoder dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .word_count (word_count),
        .done       (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    logic [WORD_W-1:0] words[$];
    logic [SYM_W-1:0]  stim[$];
    logic [SYM_W-1:0]  dec[$];
    logic              bits[$];
    logic              lb_end;

    always @(posedge clk) cyc <= cyc + 1;

    // Word acceptance is decided by values stable across the next rising edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.sram_valid && bus.sram_ready) begin
                words.push_back(bus.sram_dout);
                acc_cyc = cyc;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input int i);
        if (words.size() > i) return 32'(words[i]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        words.delete();
        done_cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_syms(input logic with_last);
        for (int i = 0; i < stim.size(); i++) begin
            int t;
            t = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = stim[i];
            bus.in_last  = with_last && (i == stim.size() - 1);
            @(negedge clk);
            while (!bus.in_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (!bus.in_ready) begin
                check_eq("in_ready_timeout", 32'(bus.in_ready), 32'd1);
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (!done) check_eq("done_timeout", 32'(done), 32'd1);
    endtask

    int ntok, exp_words, pos, bad, run_len, idx;
    logic [SYM_W-1:0] dv;
    logic [RUN_W-1:0] dr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_last    = 1'b0;
        bus.sram_ready = 1'b1;
        lb_end         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("rst_sram_valid", 32'(bus.sram_valid), 32'd0);
        check_eq("rst_sram_dout", 32'(bus.sram_dout), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_word_count", 32'(word_count), 32'd0);
        reset_n = 1'b1;
        tick();

        // Mixed runs: (2,0)(3,3)(3,0)(5,0)
        stim = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd5};
        start_frame();
        push_syms(1'b1);
        wait_done();
        check_eq("t1_nwords", 32'(words.size()), 32'd2);
        check_eq("t1_word0", word_at(0), 32'h20F3);
        check_eq("t1_word1", word_at(1), 32'h1400);
        check_eq("t1_word_count", 32'(word_count), 32'd2);
        check_eq("t1_done_latency", 32'(cyc - acc_cyc), 32'd1);
        repeat (3) tick();
        check_eq("t1_done_pulses", 32'(done_cnt), 32'd1);
        check_eq("t1_done_low", 32'(done), 32'd0);

        // Single symbol frame
        stim = '{4'd7};
        start_frame();
        push_syms(1'b1);
        wait_done();
        check_eq("t2_nwords", 32'(words.size()), 32'd1);
        check_eq("t2_word0", word_at(0), 32'h7000);
        check_eq("t2_word_count", 32'(word_count), 32'd1);
        check_eq("t2_done_latency", 32'(cyc - acc_cyc), 32'd1);

        // Eight identical symbols -> two saturated tokens, padded word
        stim = '{4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA, 4'hA};
        start_frame();
        push_syms(1'b1);
        wait_done();
        check_eq("t3_nwords", 32'(words.size()), 32'd1);
        check_eq("t3_word0", word_at(0), 32'hAEB0);
        check_eq("t3_word_count", 32'(word_count), 32'd1);

        // Backpressure on the first word
        bus.sram_ready = 1'b0;
        stim = '{4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd5};
        start_frame();
        fork
            push_syms(1'b1);
            begin
                int t;
                t = 0;
                while (!bus.sram_valid && t < 300) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("t4_first_dout", 32'(bus.sram_dout), 32'h20F3);
                repeat (10) @(negedge clk);
                check_eq("t4_hold_dout", 32'(bus.sram_dout), 32'h20F3);
                check_eq("t4_hold_valid", 32'(bus.sram_valid), 32'd1);
                check_eq("t4_none_accepted", 32'(words.size()), 32'd0);
                tick();
                bus.sram_ready = 1'b1;
            end
        join
        wait_done();
        check_eq("t4_nwords", 32'(words.size()), 32'd2);
        check_eq("t4_word0", word_at(0), 32'h20F3);
        check_eq("t4_word1", word_at(1), 32'h1400);
        check_eq("t4_word_count", 32'(word_count), 32'd2);

        // Reset in the middle of a frame
        stim = '{4'd1, 4'd2, 4'd3};
        start_frame();
        push_syms(1'b0);
        reset_n = 1'b0;
        #1;
        check_eq("t5_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("t5_sram_valid", 32'(bus.sram_valid), 32'd0);
        check_eq("t5_sram_dout", 32'(bus.sram_dout), 32'd0);
        check_eq("t5_word_count", 32'(word_count), 32'd0);
        check_eq("t5_done", 32'(done), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        stim = '{4'd7};
        start_frame();
        push_syms(1'b1);
        wait_done();
        check_eq("t5_nwords", 32'(words.size()), 32'd1);
        check_eq("t5_word0", word_at(0), 32'h7000);

        // Pseudo-random runs of 1..6 with random SRAM stalls, decoded back
        stim.delete();
        while (stim.size() < 32) begin
            dv = SYM_W'($urandom_range(0, 15));
            run_len = $urandom_range(1, 6);
            for (int k = 0; k < run_len && stim.size() < 32; k++) stim.push_back(dv);
        end
        ntok = 0;
        idx = 0;
        while (idx < stim.size()) begin
            run_len = 1;
            while (idx + run_len < stim.size() && stim[idx + run_len] == stim[idx]) run_len++;
            ntok += (run_len + 3) / 4;
            idx += run_len;
        end
        exp_words = (ntok * TOK_W + WORD_W - 1) / WORD_W;
        start_frame();
        fork
            begin
                push_syms(1'b1);
                wait_done();
                lb_end = 1'b1;
            end
            begin
                while (!lb_end) begin
                    tick();
                    bus.sram_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.sram_ready = 1'b1;
        check_eq("lb_nwords", 32'(words.size()), 32'(exp_words));
        check_eq("lb_word_count", 32'(word_count), 32'(exp_words));
        bits.delete();
        foreach (words[i]) for (int b = WORD_W - 1; b >= 0; b--) bits.push_back(words[i][b]);
        dec.delete();
        pos = 0;
        while (dec.size() < stim.size() && pos + TOK_W <= bits.size()) begin
            dv = {bits[pos], bits[pos+1], bits[pos+2], bits[pos+3]};
            dr = {bits[pos+4], bits[pos+5]};
            for (int k = 0; k <= int'(dr); k++) dec.push_back(dv);
            pos += TOK_W;
        end
        bad = 0;
        for (int i = 0; i < stim.size(); i++) begin
            if (dec.size() <= i || dec[i] !== stim[i]) bad++;
        end
        check_eq("lb_decoded_len", 32'(dec.size()), 32'(stim.size()));
        check_eq("lb_symbol_errors", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
